// File: rtl/cx_dma_hazard_ctrl.sv
// rtl/cx_dma_hazard_ctrl.sv - DMA requester: range-hazard lookup, slot allocation, issue and completion release.
// Entry layout on all entry-carrying channels: {base_address, end_address, rw}.
module cx_dma_hazard_ctrl #(
    parameter int DEPTH       = 8,
    parameter int ID_W        = 4,
    parameter int RETRY_DELAY = 4,
    parameter int ADDR_W      = 32,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int ENTRY_W    = 2 * ADDR_W + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,

    input  logic                     s_cmd_valid,
    output logic                     s_cmd_ready,
    input  logic [ENTRY_W-1:0]       s_cmd_data,
    input  logic [ID_W-1:0]          s_cmd_id,

    output logic                     m_lkup_req_valid,
    input  logic                     m_lkup_req_ready,
    output logic [ENTRY_W-1:0]       m_lkup_req_data,
    output logic [ID_W-1:0]          m_lkup_req_id,

    input  logic                     s_lkup_resp_valid,
    output logic                     s_lkup_resp_ready,
    input  logic                     s_lkup_resp_data,
    input  logic [ID_W-1:0]          s_lkup_resp_id,

    output logic                     m_alloc_req_valid,
    input  logic                     m_alloc_req_ready,
    output logic [ENTRY_W-1:0]       m_alloc_req_data,
    output logic [ID_W-1:0]          m_alloc_req_id,

    input  logic                     s_alloc_resp_valid,
    output logic                     s_alloc_resp_ready,
    input  logic [IDX_W-1:0]         s_alloc_resp_data,
    input  logic [ID_W-1:0]          s_alloc_resp_id,

    output logic                     m_issue_valid,
    input  logic                     m_issue_ready,
    output logic [IDX_W+ENTRY_W-1:0] m_issue_data,
    output logic [ID_W-1:0]          m_issue_id,

    input  logic                     s_done_valid,
    output logic                     s_done_ready,
    input  logic [IDX_W-1:0]         s_done_data,

    output logic                     m_remove_req_valid,
    input  logic                     m_remove_req_ready,
    output logic [IDX_W-1:0]         m_remove_req_data,

    output logic                     o_range_err,
    output logic [15:0]              o_conflict_cnt,
    output logic [IDX_W:0]           o_outstanding
);

    localparam int BO_W = (RETRY_DELAY < 1) ? 1 : $clog2(RETRY_DELAY + 1);

    typedef enum logic [2:0] {
        IDLE,
        LKUP,
        LKUP_WAIT,
        BACKOFF,
        ALLOC,
        ALLOC_WAIT,
        ISSUE
    } state_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   entry_q;
    logic [ID_W-1:0]      id_q;
    logic [IDX_W-1:0]     idx_q;
    logic [BO_W-1:0]      backoff_q;
    logic                 range_err_q;
    logic [15:0]          conflict_q;
    logic [IDX_W:0]       outstanding_q;

    logic [ADDR_W-1:0]    cmd_base;
    logic [ADDR_W-1:0]    cmd_end;
    logic                 range_bad;
    logic                 cmd_hs;
    logic                 conflict_hs;
    logic                 issue_hs;
    logic                 remove_hs;

    assign cmd_base  = s_cmd_data[ENTRY_W-1 -: ADDR_W];
    assign cmd_end   = s_cmd_data[ADDR_W:1];
    assign range_bad = cmd_end < cmd_base;

    assign cmd_hs      = s_cmd_valid && s_cmd_ready;
    assign conflict_hs = s_lkup_resp_valid && s_lkup_resp_ready && s_lkup_resp_data;
    assign issue_hs    = m_issue_valid && m_issue_ready;
    assign remove_hs   = s_done_valid && m_remove_req_ready;

    always_comb begin
        state_d            = state_q;
        s_cmd_ready        = 1'b0;
        m_lkup_req_valid   = 1'b0;
        s_lkup_resp_ready  = 1'b0;
        m_alloc_req_valid  = 1'b0;
        s_alloc_resp_ready = 1'b0;
        m_issue_valid      = 1'b0;
        case (state_q)
            IDLE: begin
                s_cmd_ready = outstanding_q < (IDX_W + 1)'(DEPTH);
                if (s_cmd_valid && s_cmd_ready && !range_bad) state_d = LKUP;
            end
            LKUP: begin
                m_lkup_req_valid = 1'b1;
                if (m_lkup_req_ready) state_d = LKUP_WAIT;
            end
            LKUP_WAIT: begin
                s_lkup_resp_ready = 1'b1;
                if (s_lkup_resp_valid) state_d = s_lkup_resp_data ? BACKOFF : ALLOC;
            end
            BACKOFF: begin
                if (backoff_q <= BO_W'(1)) state_d = LKUP;
            end
            ALLOC: begin
                m_alloc_req_valid = 1'b1;
                if (m_alloc_req_ready) state_d = ALLOC_WAIT;
            end
            ALLOC_WAIT: begin
                s_alloc_resp_ready = 1'b1;
                if (s_alloc_resp_valid) state_d = ISSUE;
            end
            ISSUE: begin
                m_issue_valid = 1'b1;
                if (m_issue_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            entry_q       <= '0;
            id_q          <= '0;
            idx_q         <= '0;
            backoff_q     <= '0;
            range_err_q   <= 1'b0;
            conflict_q    <= '0;
            outstanding_q <= '0;
        end else begin
            state_q     <= state_d;
            range_err_q <= cmd_hs && range_bad;
            if (cmd_hs) begin
                entry_q <= s_cmd_data;
                id_q    <= s_cmd_id;
            end
            if (conflict_hs) begin
                backoff_q <= BO_W'(RETRY_DELAY);
                if (conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
            end else if (state_q == BACKOFF && backoff_q != '0) begin
                backoff_q <= backoff_q - BO_W'(1);
            end
            if (s_alloc_resp_valid && s_alloc_resp_ready) idx_q <= s_alloc_resp_data;
            // Issue and remove in the same cycle cancel out.
            case ({issue_hs, remove_hs})
                2'b10:   outstanding_q <= outstanding_q + (IDX_W + 1)'(1);
                2'b01:   outstanding_q <= outstanding_q - (IDX_W + 1)'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign m_lkup_req_data   = entry_q;
    assign m_lkup_req_id     = id_q;
    assign m_alloc_req_data  = entry_q;
    assign m_alloc_req_id    = id_q;
    assign m_issue_data      = {idx_q, entry_q};
    assign m_issue_id        = id_q;

    assign m_remove_req_valid = s_done_valid;
    assign m_remove_req_data  = s_done_data;
    assign s_done_ready       = m_remove_req_ready;

    assign o_range_err    = range_err_q;
    assign o_conflict_cnt = conflict_q;
    assign o_outstanding  = outstanding_q;

    a_lkup_id: assert property (@(posedge i_clk) disable iff (i_rst)
        (s_lkup_resp_valid && s_lkup_resp_ready) |-> (s_lkup_resp_id == id_q));
    a_alloc_id: assert property (@(posedge i_clk) disable iff (i_rst)
        (s_alloc_resp_valid && s_alloc_resp_ready) |-> (s_alloc_resp_id == id_q));
    a_remove_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        remove_hs |-> (outstanding_q != '0));
    a_outstanding_max: assert property (@(posedge i_clk) disable iff (i_rst)
        outstanding_q <= (IDX_W + 1)'(DEPTH));

endmodule

// File: tb/tb_cx_dma_hazard_ctrl.sv
// tb/tb_cx_dma_hazard_ctrl.sv - self-checking bench for cx_dma_hazard_ctrl with transaction-level model.
module tb_cx_dma_hazard_ctrl;

    localparam int DEPTH = 8;
    localparam int ID_W  = 4;
    localparam int RD    = 4;
    localparam int AW    = 32;
    localparam int IW    = 3;
    localparam int EW    = 2 * AW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            s_cmd_valid, s_cmd_ready;
    logic [EW-1:0]   s_cmd_data;
    logic [ID_W-1:0] s_cmd_id;
    logic            m_lkup_req_valid, m_lkup_req_ready;
    logic [EW-1:0]   m_lkup_req_data;
    logic [ID_W-1:0] m_lkup_req_id;
    logic            s_lkup_resp_valid, s_lkup_resp_ready, s_lkup_resp_data;
    logic [ID_W-1:0] s_lkup_resp_id;
    logic            m_alloc_req_valid, m_alloc_req_ready;
    logic [EW-1:0]   m_alloc_req_data;
    logic [ID_W-1:0] m_alloc_req_id;
    logic            s_alloc_resp_valid, s_alloc_resp_ready;
    logic [IW-1:0]   s_alloc_resp_data;
    logic [ID_W-1:0] s_alloc_resp_id;
    logic            m_issue_valid, m_issue_ready;
    logic [IW+EW-1:0] m_issue_data;
    logic [ID_W-1:0] m_issue_id;
    logic            s_done_valid, s_done_ready;
    logic [IW-1:0]   s_done_data;
    logic            m_remove_req_valid, m_remove_req_ready;
    logic [IW-1:0]   m_remove_req_data;
    logic            o_range_err;
    logic [15:0]     o_conflict_cnt;
    logic [IW:0]     o_outstanding;

    cx_dma_hazard_ctrl #(.DEPTH(DEPTH), .ID_W(ID_W), .RETRY_DELAY(RD), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_data(s_cmd_data), .s_cmd_id(s_cmd_id),
        .m_lkup_req_valid(m_lkup_req_valid), .m_lkup_req_ready(m_lkup_req_ready),
        .m_lkup_req_data(m_lkup_req_data), .m_lkup_req_id(m_lkup_req_id),
        .s_lkup_resp_valid(s_lkup_resp_valid), .s_lkup_resp_ready(s_lkup_resp_ready),
        .s_lkup_resp_data(s_lkup_resp_data), .s_lkup_resp_id(s_lkup_resp_id),
        .m_alloc_req_valid(m_alloc_req_valid), .m_alloc_req_ready(m_alloc_req_ready),
        .m_alloc_req_data(m_alloc_req_data), .m_alloc_req_id(m_alloc_req_id),
        .s_alloc_resp_valid(s_alloc_resp_valid), .s_alloc_resp_ready(s_alloc_resp_ready),
        .s_alloc_resp_data(s_alloc_resp_data), .s_alloc_resp_id(s_alloc_resp_id),
        .m_issue_valid(m_issue_valid), .m_issue_ready(m_issue_ready),
        .m_issue_data(m_issue_data), .m_issue_id(m_issue_id),
        .s_done_valid(s_done_valid), .s_done_ready(s_done_ready), .s_done_data(s_done_data),
        .m_remove_req_valid(m_remove_req_valid), .m_remove_req_ready(m_remove_req_ready),
        .m_remove_req_data(m_remove_req_data),
        .o_range_err(o_range_err), .o_conflict_cnt(o_conflict_cnt), .o_outstanding(o_outstanding)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input logic [AW-1:0] b, input logic [AW-1:0] e, input logic rw);
        return {b, e, rw};
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log: cycle numbers of handshakes seen on each channel.
    int cmd_cyc[$];
    int lk_cyc[$];
    int rs_cyc[$];
    int is_cyc[$];
    logic [IW+EW-1:0] is_dat[$];
    int err_cnt = 0;
    int al_cnt  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (s_cmd_valid && s_cmd_ready) cmd_cyc.push_back(cyc);
            if (m_lkup_req_valid && m_lkup_req_ready) lk_cyc.push_back(cyc);
            if (s_lkup_resp_valid && s_lkup_resp_ready) rs_cyc.push_back(cyc);
            if (m_issue_valid && m_issue_ready) begin
                is_cyc.push_back(cyc);
                is_dat.push_back(m_issue_data);
            end
            if (m_alloc_req_valid && m_alloc_req_ready) al_cnt++;
            if (o_range_err) err_cnt++;
        end
    end

    // Transaction-level model: one command in flight, a counter of issued-not-removed, a conflict tally.
    int               md_out;
    int               md_conf;
    logic             md_busy, md_err;
    logic [EW-1:0]    md_entry;
    logic [ID_W-1:0]  md_id;
    logic [IW-1:0]    md_idx;
    logic             pv_issue, pr_issue, pv_lkup, pr_lkup;
    logic [IW+EW-1:0] pd_issue;
    logic [EW-1:0]    pd_lkup;

    always @(negedge clk) begin
        if (rst) begin
            md_out = 0; md_conf = 0; md_busy = 1'b0; md_err = 1'b0;
            md_entry = '0; md_id = '0; md_idx = '0;
            pv_issue = 1'b0; pr_issue = 1'b0; pv_lkup = 1'b0; pr_lkup = 1'b0;
            pd_issue = '0; pd_lkup = '0;
            check("rst_outstanding", o_outstanding, 0);
            check("rst_conflict", o_conflict_cnt, 0);
            check("rst_valids", {m_lkup_req_valid, m_alloc_req_valid, m_issue_valid,
                                 s_lkup_resp_ready, s_alloc_resp_ready, o_range_err}, 0);
        end else begin
            check("outstanding", o_outstanding, md_out);
            check("conflict_cnt", o_conflict_cnt, md_conf);
            check("range_err", o_range_err, md_err);
            check("cmd_ready", s_cmd_ready, (!md_busy && md_out < DEPTH));
            check("remove_valid", m_remove_req_valid, s_done_valid);
            check("remove_data", m_remove_req_data, s_done_data);
            check("done_ready", s_done_ready, m_remove_req_ready);
            if (m_lkup_req_valid) begin
                check("lkup_busy", md_busy, 1);
                check("lkup_data", {m_lkup_req_data, m_lkup_req_id}, {md_entry, md_id});
            end
            if (m_alloc_req_valid)
                check("alloc_data", {m_alloc_req_data, m_alloc_req_id}, {md_entry, md_id});
            if (m_issue_valid)
                check("issue_data", {m_issue_data, m_issue_id}, {md_idx, md_entry, md_id});
            if (pv_issue && !pr_issue)
                check("issue_hold", {m_issue_valid, m_issue_data}, {1'b1, pd_issue});
            if (pv_lkup && !pr_lkup)
                check("lkup_hold", {m_lkup_req_valid, m_lkup_req_data}, {1'b1, pd_lkup});

            md_err = 1'b0;
            if (s_cmd_valid && s_cmd_ready) begin
                if (s_cmd_data[AW:1] < s_cmd_data[EW-1:AW+1]) md_err = 1'b1;
                else begin
                    md_busy  = 1'b1;
                    md_entry = s_cmd_data;
                    md_id    = s_cmd_id;
                end
            end
            if (s_lkup_resp_valid && s_lkup_resp_ready && s_lkup_resp_data && md_conf < 16'hFFFF)
                md_conf++;
            if (s_alloc_resp_valid && s_alloc_resp_ready) md_idx = s_alloc_resp_data;
            if (m_issue_valid && m_issue_ready) begin
                md_busy = 1'b0;
                md_out++;
            end
            if (s_done_valid && s_done_ready) md_out--;
            pv_issue = m_issue_valid; pr_issue = m_issue_ready; pd_issue = m_issue_data;
            pv_lkup = m_lkup_req_valid; pr_lkup = m_lkup_req_ready; pd_lkup = m_lkup_req_data;
        end
    end

    // Tracker model: answers one cycle after each request, conflicts drawn from conf_q.
    logic          conf_q[$];
    logic [IW-1:0] next_idx = '0;

    initial begin
        logic lk_hs, lk_tk, al_hs, al_tk;
        logic [ID_W-1:0] lk_id, al_id;
        s_lkup_resp_valid = 1'b0; s_lkup_resp_data = 1'b0; s_lkup_resp_id = '0;
        s_alloc_resp_valid = 1'b0; s_alloc_resp_data = '0; s_alloc_resp_id = '0;
        forever begin
            @(negedge clk);
            lk_hs = !rst && m_lkup_req_valid && m_lkup_req_ready;
            lk_id = m_lkup_req_id;
            lk_tk = s_lkup_resp_valid && s_lkup_resp_ready;
            al_hs = !rst && m_alloc_req_valid && m_alloc_req_ready;
            al_id = m_alloc_req_id;
            al_tk = s_alloc_resp_valid && s_alloc_resp_ready;
            @(posedge clk);
            #1;
            if (rst) begin
                s_lkup_resp_valid  = 1'b0;
                s_alloc_resp_valid = 1'b0;
            end else begin
                if (lk_tk) s_lkup_resp_valid = 1'b0;
                if (lk_hs) begin
                    s_lkup_resp_valid = 1'b1;
                    s_lkup_resp_id    = lk_id;
                    if (conf_q.size() > 0) s_lkup_resp_data = conf_q.pop_front();
                    else s_lkup_resp_data = 1'b0;
                end
                if (al_tk) s_alloc_resp_valid = 1'b0;
                if (al_hs) begin
                    s_alloc_resp_valid = 1'b1;
                    s_alloc_resp_id    = al_id;
                    s_alloc_resp_data  = next_idx;
                    next_idx           = next_idx + 3'd1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [EW-1:0] d, input logic [ID_W-1:0] id);
        int n = 0;
        s_cmd_valid = 1'b1;
        s_cmd_data  = d;
        s_cmd_id    = id;
        do begin
            @(negedge clk);
            n++;
        end while (!s_cmd_ready && n < 200);
        check("cmd_accept_timeout", s_cmd_ready, 1);
        @(posedge clk);
        #1;
        s_cmd_valid = 1'b0;
    endtask

    task automatic wait_issues(input int target);
        int n = 0;
        while (is_cyc.size() < target && n < 100) begin
            tick(1);
            n++;
        end
        check("issue_timeout", is_cyc.size() >= target, 1);
    endtask

    task automatic wait_issue_valid();
        int n = 0;
        while (!m_issue_valid && n < 100) begin
            tick(1);
            n++;
        end
        check("issue_valid_timeout", m_issue_valid, 1);
    endtask

    task automatic do_done(input logic [IW-1:0] idx);
        s_done_valid = 1'b1;
        s_done_data  = idx;
        #1;
        check("remove_comb_valid", m_remove_req_valid, 1);
        check("remove_comb_data", m_remove_req_data, idx);
        tick(1);
        s_done_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lk0, rs0, is0, e0, a0, n;
        logic [IW+EW-1:0] held;
        s_cmd_valid = 1'b0; s_cmd_data = '0; s_cmd_id = '0;
        m_lkup_req_ready = 1'b1; m_alloc_req_ready = 1'b1; m_issue_ready = 1'b1;
        m_remove_req_ready = 1'b1; s_done_valid = 1'b0; s_done_data = '0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick(1);
        check("t0_ready", s_cmd_ready, 1);
        check("t0_outstanding", o_outstanding, 0);
        check("t0_conflict", o_conflict_cnt, 0);
        check("t0_remove_follows", m_remove_req_valid, 0);

        // Single command, minimum latency.
        send_cmd(ent(32'h100, 32'h1FF, 1'b1), 4'h3);
        wait_issues(1);
        check("t1_latency", is_cyc[0] - cmd_cyc[0], 5);
        check("t1_issue_data", is_dat[0], {3'd0, 32'h100, 32'h1FF, 1'b1});
        check("t1_outstanding", o_outstanding, 1);
        do_done(3'd0);
        check("t1_after_done", o_outstanding, 0);

        // Two conflicts then a clear lookup.
        conf_q.push_back(1'b1);
        conf_q.push_back(1'b1);
        lk0 = lk_cyc.size(); rs0 = rs_cyc.size(); is0 = is_cyc.size();
        send_cmd(ent(32'h2000, 32'h20FF, 1'b0), 4'h5);
        wait_issues(is0 + 1);
        tick(2);
        check("t2_lookups", lk_cyc.size() - lk0, 3);
        check("t2_conflict_cnt", o_conflict_cnt, 2);
        check("t2_gap0", lk_cyc[lk0 + 1] - rs_cyc[rs0], 5);
        check("t2_gap1", lk_cyc[lk0 + 2] - rs_cyc[rs0 + 1], 5);
        check("t2_issues", is_cyc.size() - is0, 1);
        check("t2_issue_data", is_dat[is0], {3'd1, 32'h2000, 32'h20FF, 1'b0});
        do_done(3'd1);

        // Inverted range is dropped.
        e0 = err_cnt; lk0 = lk_cyc.size(); a0 = al_cnt; is0 = is_cyc.size();
        send_cmd(ent(32'h100, 32'h0FF, 1'b0), 4'h6);
        check("t3_err_pulse", o_range_err, 1);
        check("t3_ready_back", s_cmd_ready, 1);
        tick(3);
        check("t3_err_once", err_cnt - e0, 1);
        check("t3_no_lkup", lk_cyc.size() - lk0, 0);
        check("t3_no_alloc", al_cnt - a0, 0);
        check("t3_no_issue", is_cyc.size() - is0, 0);

        // Issue backpressure for 10 cycles.
        m_issue_ready = 1'b0;
        send_cmd(ent(32'h3000, 32'h30FF, 1'b1), 4'h7);
        wait_issue_valid();
        held = m_issue_data;
        check("t4_issue_literal", held, {3'd2, 32'h3000, 32'h30FF, 1'b1});
        repeat (10) begin
            @(negedge clk);
            check("t4_valid_held", m_issue_valid, 1);
            check("t4_data_held", m_issue_data, held);
            check("t4_cmd_blocked", s_cmd_ready, 0);
        end
        tick(1);
        m_issue_ready = 1'b1;
        tick(1);
        check("t4_outstanding", o_outstanding, 1);
        do_done(3'd2);

        // Fill all slots.
        for (int i = 0; i < DEPTH; i++)
            send_cmd(ent(32'h10000 + i * 32'h100, 32'h100FF + i * 32'h100, i[0]), ID_W'(i));
        n = 0;
        while (o_outstanding != 4'(DEPTH) && n < 50) begin
            tick(1);
            n++;
        end
        check("t5_full_count", o_outstanding, 8);
        check("t5_full_ready", s_cmd_ready, 0);
        tick(2);
        check("t5_still_blocked", s_cmd_ready, 0);
        do_done(3'd0);
        check("t5_ready_returns", s_cmd_ready, 1);
        check("t5_count7", o_outstanding, 7);
        m_issue_ready = 1'b0;
        send_cmd(ent(32'h5000, 32'h5000, 1'b0), 4'h9);
        wait_issue_valid();
        m_issue_ready = 1'b1;
        s_done_valid = 1'b1;
        s_done_data  = 3'd4;
        tick(1);
        s_done_valid = 1'b0;
        check("t5_simultaneous", o_outstanding, 7);
        for (int i = 0; i < 6; i++) do_done(IW'(i));
        check("t5_drained", o_outstanding, 1);

        // Asynchronous reset while waiting for the allocation response.
        a0 = al_cnt;
        send_cmd(ent(32'h6000, 32'h60FF, 1'b1), 4'hA);
        n = 0;
        while (al_cnt == a0 && n < 50) begin
            tick(1);
            n++;
        end
        check("t6_in_alloc_wait", s_alloc_resp_ready, 1);
        check("t6_pre_conflict", o_conflict_cnt, 2);
        #1 rst = 1'b1;
        #1;
        check("t6_async_valids", {m_lkup_req_valid, m_alloc_req_valid, m_issue_valid,
                                  s_lkup_resp_ready, s_alloc_resp_ready}, 0);
        check("t6_async_outstanding", o_outstanding, 0);
        check("t6_async_conflict", o_conflict_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick(1);
        check("t6_idle_ready", s_cmd_ready, 1);
        is0 = is_cyc.size();
        send_cmd(ent(32'h7000, 32'h70FF, 1'b0), 4'hB);
        wait_issues(is0 + 1);
        check("t6_post_reset_issue", o_outstanding, 1);
        do_done(3'd0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
